// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone B4 classic slave. Host writes are posted into a
// command FIFO for the back-end. Back-end responses queue in a response FIFO
// that the host reads. Sticky error flags and a level interrupt are included.
module wb_fifo_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CMD_DEPTH  = 8,
    parameter int unsigned RSP_DEPTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [1:0]            adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [DATA_WIDTH-1:0] rsp_data_i
);

    localparam int unsigned CMD_PW = $clog2(CMD_DEPTH);
    localparam int unsigned CMD_CW = CMD_PW + 1;
    localparam int unsigned RSP_PW = $clog2(RSP_DEPTH);
    localparam int unsigned RSP_CW = RSP_PW + 1;

    localparam logic [1:0] ADR_CMD    = 2'd0;
    localparam logic [1:0] ADR_RSP    = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    localparam logic [CMD_CW-1:0] CMD_FULL_CNT = CMD_CW'(CMD_DEPTH);
    localparam logic [RSP_CW-1:0] RSP_FULL_CNT = RSP_CW'(RSP_DEPTH);

    // Storage arrays (data only; validity is tracked by pointers and counts)
    logic [DATA_WIDTH-1:0] cmd_mem_q [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] rsp_mem_q [RSP_DEPTH];

    // Command FIFO state
    logic [CMD_PW-1:0] cmd_wr_q, cmd_wr_d;
    logic [CMD_PW-1:0] cmd_rd_q, cmd_rd_d;
    logic [CMD_CW-1:0] cmd_cnt_q, cmd_cnt_d;

    // Response FIFO state
    logic [RSP_PW-1:0] rsp_wr_q, rsp_wr_d;
    logic [RSP_PW-1:0] rsp_rd_q, rsp_rd_d;
    logic [RSP_CW-1:0] rsp_cnt_q, rsp_cnt_d;

    // Bus-side registers
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  irq_q, irq_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  irq_en_q, irq_en_d;

    // Decoded events for the current edge
    logic                  req;
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  flush;
    logic                  cmd_empty, cmd_full;
    logic                  rsp_empty, rsp_full;
    logic                  cmd_push_req, cmd_push, cmd_pop;
    logic                  rsp_pop_req, rsp_pop, rsp_push;
    logic                  cmd_mem_we, rsp_mem_we;
    logic [DATA_WIDTH-1:0] cmd_head;
    logic [DATA_WIDTH-1:0] rsp_head;
    logic [23:0]           status_bits;

    // FIFO flags, heads and the STATUS image
    always_comb begin
        cmd_empty   = (cmd_cnt_q == '0);
        cmd_full    = (cmd_cnt_q == CMD_FULL_CNT);
        rsp_empty   = (rsp_cnt_q == '0);
        rsp_full    = (rsp_cnt_q == RSP_FULL_CNT);
        cmd_head    = cmd_empty ? '0 : cmd_mem_q[cmd_rd_q];
        rsp_head    = rsp_mem_q[rsp_rd_q];
        status_bits = {8'(rsp_cnt_q), 8'(cmd_cnt_q), 2'b00, udf_q, ovf_q,
                       rsp_empty, rsp_full, cmd_empty, cmd_full};
    end

    // Transfer decode and FIFO push/pop qualification
    always_comb begin
        req          = cyc_i & stb_i & ~ack_q;
        bus_wr       = req & we_i;
        bus_rd       = req & ~we_i;
        flush        = bus_wr & (adr_i == ADR_CTRL) & dat_i[1];
        cmd_pop      = ~cmd_empty & cmd_ready_i;
        cmd_push_req = bus_wr & (adr_i == ADR_CMD);
        // A full FIFO still accepts a push when the head leaves on the same edge
        cmd_push     = cmd_push_req & (~cmd_full | cmd_pop);
        rsp_push     = rsp_valid_i & ~rsp_full;
        rsp_pop_req  = bus_rd & (adr_i == ADR_RSP);
        rsp_pop      = rsp_pop_req & ~rsp_empty;
        cmd_mem_we   = cmd_push & ~flush;
        rsp_mem_we   = rsp_push & ~flush;
    end

    // Next-state for pointers, counts, flags, control and bus outputs
    always_comb begin
        cmd_wr_d  = cmd_wr_q;
        cmd_rd_d  = cmd_rd_q;
        cmd_cnt_d = cmd_cnt_q;
        rsp_wr_d  = rsp_wr_q;
        rsp_rd_d  = rsp_rd_q;
        rsp_cnt_d = rsp_cnt_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        irq_en_d  = irq_en_q;
        ack_d     = req;
        dat_d     = '0;
        irq_d     = irq_en_q & (~rsp_empty | ovf_q | udf_q);

        if (flush) begin
            cmd_wr_d  = '0;
            cmd_rd_d  = '0;
            cmd_cnt_d = '0;
            rsp_wr_d  = '0;
            rsp_rd_d  = '0;
            rsp_cnt_d = '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_d = cmd_wr_q + CMD_PW'(1);
            end
            if (cmd_pop) begin
                cmd_rd_d = cmd_rd_q + CMD_PW'(1);
            end
            cmd_cnt_d = cmd_cnt_q + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
            if (rsp_push) begin
                rsp_wr_d = rsp_wr_q + RSP_PW'(1);
            end
            if (rsp_pop) begin
                rsp_rd_d = rsp_rd_q + RSP_PW'(1);
            end
            rsp_cnt_d = rsp_cnt_q + RSP_CW'(rsp_push) - RSP_CW'(rsp_pop);
        end

        // Write-1-to-clear first so that a coincident set event wins
        if (bus_wr && (adr_i == ADR_STATUS)) begin
            if (dat_i[4]) begin
                ovf_d = 1'b0;
            end
            if (dat_i[5]) begin
                udf_d = 1'b0;
            end
        end
        if (cmd_push_req && cmd_full && !cmd_pop) begin
            ovf_d = 1'b1;
        end
        if (rsp_pop_req && rsp_empty) begin
            udf_d = 1'b1;
        end

        if (bus_wr && (adr_i == ADR_CTRL)) begin
            irq_en_d = dat_i[0];
        end

        if (bus_rd) begin
            case (adr_i)
                ADR_CMD:    dat_d = cmd_head;
                ADR_RSP:    dat_d = rsp_pop ? rsp_head : '0;
                ADR_STATUS: dat_d = DATA_WIDTH'(status_bits);
                default:    dat_d = DATA_WIDTH'(irq_en_q);
            endcase
        end
    end

    // Control and status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            cmd_wr_q  <= cmd_wr_d;
            cmd_rd_q  <= cmd_rd_d;
            cmd_cnt_q <= cmd_cnt_d;
            rsp_wr_q  <= rsp_wr_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_cnt_q <= rsp_cnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_en_q  <= irq_en_d;
        end
    end

    // FIFO storage writes; contents need no reset
    always_ff @(posedge clk_i) begin
        if (cmd_mem_we) begin
            cmd_mem_q[cmd_wr_q] <= dat_i;
        end
        if (rsp_mem_we) begin
            rsp_mem_q[rsp_wr_q] <= rsp_data_i;
        end
    end

    assign dat_o       = dat_q;
    assign ack_o       = ack_q;
    assign irq_o       = irq_q;
    assign cmd_valid_o = ~cmd_empty;
    assign cmd_data_o  = cmd_head;
    assign rsp_ready_o = ~rsp_full;

endmodule

// File: doc/wb_fifo_slave.md
Name: wb_fifo_slave

Overview:
- Parametrised Wishbone B4 classic slave that decouples the host from the I2CMB back-end.
- Host writes are posted into a command FIFO. Back-end responses queue in a response FIFO for the host to read.
- Generalises the single-register WB slave path with configurable data width, independent FIFO depths, sticky error flags and an interrupt.
- Sits between the WB bus functional interface and the bus-controller core.

Parameters:
- DATA_WIDTH, 32, WB data width; legal values 24..64.
- CMD_DEPTH, 8, command FIFO entries; power of two, 2..128.
- RSP_DEPTH, 8, response FIFO entries; power of two, 2..128.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cyc_i  in  1  WB cycle
- stb_i  in  1  WB strobe
- we_i  in  1  WB write enable
- adr_i  in  2  register address
- dat_i  in  DATA_WIDTH  WB write data
- dat_o  out  DATA_WIDTH  WB read data
- ack_o  out  1  WB acknowledge
- irq_o  out  1  interrupt, level
- cmd_valid_o  out  1  command FIFO not empty
- cmd_ready_i  in  1  back-end consumes head command
- cmd_data_o  out  DATA_WIDTH  command FIFO head
- rsp_valid_i  in  1  back-end offers response
- rsp_ready_o  out  1  response FIFO not full
- rsp_data_i  in  DATA_WIDTH  response data

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: dat_o=0, ack_o=0, irq_o=0, cmd_valid_o=0, rsp_ready_o=1, cmd_data_o=0. Both FIFOs empty. Sticky flags=0. CTRL=0.
- Reset mid-transfer: reset asserted during any transfer aborts it. No side effect survives, and no ack is issued.
- WB handshake:
  - When cyc_i&stb_i&!ack_o, ack_o is registered high on the next edge and held for exactly one cycle.
  - Back-to-back transfers therefore ack every other cycle.
  - Register side effects and the dat_o update occur on the same edge that raises ack_o.
  - dat_o returns 0 when ack_o is low.
- Address 0, CMD:
  - Write pushes dat_i into the command FIFO. A write while full is acked, the data is dropped and CMD_OVF is set.
  - Read returns the head without popping.
- Address 1, RSP:
  - Read pops the response FIFO and returns the popped word. A read while empty returns 0, is acked and sets RSP_UDF.
  - Write has no effect.
- Address 2, STATUS, read:
  - [0] cmd_full, [1] cmd_empty, [2] rsp_full, [3] rsp_empty.
  - [4] CMD_OVF, [5] RSP_UDF.
  - [15:8] cmd_count, [23:16] rsp_count; counts zero-extended to 8 bits. Other bits 0.
  - Write: bits [5:4] are write-1-to-clear.
- Address 3, CTRL:
  - [0] irq_en.
  - [1] flush: write 1 empties both FIFOs on the ack edge; reads back 0.
  - Other bits read 0.
- irq_o is registered: irq_en & (!rsp_empty | CMD_OVF | RSP_UDF), with a one-cycle lag from the source condition.
- Command FIFO back-end side:
  - cmd_valid_o = !cmd_empty; cmd_data_o = head.
  - A pop occurs on cmd_valid_o&cmd_ready_i.
  - Word acked on edge N appears on cmd_valid_o/cmd_data_o after edge N (visible in cycle N+1) if the FIFO was empty.
- Response FIFO back-end side:
  - rsp_ready_o = !rsp_full; a push occurs on rsp_valid_i&rsp_ready_o.
  - The response FIFO can never overflow.
- Simultaneous events:
  - Push and pop on the same FIFO in the same edge: both take effect and the count is unchanged. This includes the full case: a WB push into a full command FIFO that is popped on the same edge is accepted, not flagged.
  - Pop from an empty FIFO in the same edge as a push: only the push takes effect.
  - Flush and push/pop on the same edge: flush wins. Both FIFOs end empty and no flag is set.
  - W1C and a new set event on the same edge: the set wins.
- Pointers: wrap modulo depth. Full/empty are derived from a count register of width clog2(DEPTH)+1.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> all outputs at reset values immediately; STATUS reads 0x00_00_0A.
- Write path: write 0x11,0x22,0x33 to CMD with cmd_ready_i=0 -> STATUS=0x00_03_08. Then raise cmd_ready_i -> cmd_data_o sequence 0x11,0x22,0x33 on consecutive cycles, then cmd_valid_o=0.
- Overflow: CMD_DEPTH=8, cmd_ready_i=0, nine writes of 0x1..0x9:
  - STATUS bit0=1, bit4=1, cmd_count=8.
  - Drain -> 0x1..0x8 only.
  - Write STATUS 0x10 -> bit4 clears.
- Response and irq: CTRL=0x1, push 0xA5 via rsp_valid_i -> irq_o high within 2 cycles. Read RSP -> 0xA5, irq_o falls. Second read -> 0, RSP_UDF=1, irq_o re-asserts.
- Full-concurrency: command FIFO full, WB CMD write on the same edge as back-end pop -> cmd_count stays 8, no CMD_OVF, new word last in order.
- Wrap and flush: 20 interleaved push/pop pairs on depth 8 -> order preserved across wrap. CTRL write 0x2 on the same edge as rsp push -> both FIFOs empty, STATUS=0x00_00_0A.
